onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter in front of the 1024x32 single-port on-chip RAM: Nios data master on port 0, DMA/debug master on port 1.
- Grants one transfer per clock, drives the RAM s1 signals, and routes 1-cycle-latency read data back to the issuing port.
- Supports round-robin or fixed-priority arbitration.

Parameters:
ADDR_W, 10, word address width (RAM depth 2^ADDR_W)
DATA_W, 32, data width; byteenable width is DATA_W/8
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  port 0 word address
m0_byteenable  in  DATA_W/8  port 0 byte lanes
m0_read  in  1  port 0 read request
m0_write  in  1  port 0 write request
m0_writedata  in  DATA_W  port 0 write data
m0_waitrequest  out  1  port 0 stall
m0_readdata  out  DATA_W  port 0 read data
m0_readdatavalid  out  1  port 0 read data strobe
m1_* (address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid)  same as m0_*, for port 1
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  DATA_W/8  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken, tied 1
mem_readdata  in  DATA_W  from RAM, valid the cycle after address is sampled

Behaviour:
- Request: reqN = mN_read | mN_write. mN_read and mN_write both high in one cycle is illegal; treat as write.
- Grant is combinational in the request cycle:
  - One requester: it is granted.
  - Both request, FIXED_PRIO=1: port 0 granted.
  - Both request, FIXED_PRIO=0: the port that is not last_grant is granted.
- last_grant register updates to the granted port on every accepted transfer, read or write. Reset value 1, so port 0 wins the first contention.
- Accepted transfer: granted port sees waitrequest=0. The losing requester sees waitrequest=1 and must hold its signals.
- Idle port (no request): waitrequest=0.
- RAM drive:
  - mem_address, mem_byteenable, mem_writedata are muxed from the granted port.
  - mem_chipselect=1 only when a grant exists.
  - mem_write = granted port's write.
  - With no grant, mem_* data outputs are don't-care and mem_chipselect=0.
- Read return pipeline:
  - Registers rd_vld and rd_tag are set at the edge that accepts a read.
  - Next cycle: mN_readdatavalid = rd_vld & (rd_tag==N). mN_readdata = mem_readdata, passed combinationally to both ports.
  - Read latency is exactly 1 cycle. Throughput is 1 transfer/cycle; back-to-back reads from alternating ports are allowed.
- Writes produce no response. A read of an address written in the previous cycle returns the new data (RAM registered address; DONT_CARE only applies to same-cycle read-during-write, which cannot occur on a single port).
- Reset (reset_n=0, async): rd_vld=0, rd_tag=0, last_grant=1. Outputs during reset:
  - readdatavalid=0 on both ports.
  - waitrequest=1 on both ports.
  - mem_chipselect=0, mem_write=0.
- Reset mid-read: pending readdatavalid is dropped; the read is lost and not replayed.
- First cycle after reset release: normal arbitration.
- Fairness (round-robin): under continuous contention, grants alternate 0,1,0,1…; no port waits more than 1 cycle.

Test Plan:
- Reset release, m0 writes 0xDEADBEEF to addr 5 with byteenable 0xF, then reads addr 5 → m0_waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with m0_readdata=0xDEADBEEF; m1_readdatavalid stays 0.
- Contention, FIXED_PRIO=0: m0 and m1 both hold reads (m0 addr 1, m1 addr 2) for 4 cycles after reset → grants 0,1,0,1; readdatavalid alternates m0,m1 one cycle later; each waitrequest=1 on alternate cycles.
- Contention, FIXED_PRIO=1: both request continuously → m0 granted every cycle; m1_waitrequest stays 1 until m0 drops its request, then m1 is granted the same cycle.
- Byte lanes: m1 writes 0x11223344 to addr 1023 with byteenable 0x5 over prior content 0xAAAAAAAA, then reads back → 0xAA22AA44 (top address, no wrap).
- Reset mid-read: assert reset_n=0 in the cycle after an accepted m1 read → m1_readdatavalid never pulses; after release, a fresh m0 read is granted first (last_grant=1).
- Write-then-read: m0 writes addr 7 in cycle N, m1 reads addr 7 in cycle N+1 → m1_readdata equals the new data in cycle N+2.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port on-chip RAM.
// One transfer per clock; 1-cycle read data is steered back to the issuing port.
module onchip_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic wr_sel;
    logic accept_rd;
    logic rd_vld;
    logic rd_tag;
    logic last_grant;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Port 0 wins contention under fixed priority, or when port 1 won last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            if (req0 && (!req1 || (FIXED_PRIO != 0) || last_grant)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    // Read and write together is treated as a write.
    assign wr_sel    = gnt1 ? m1_write : m0_write;
    assign accept_rd = any_gnt & ~wr_sel;

    assign mem_address    = gnt1 ? m1_address    : m0_address;
    assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = any_gnt;
    assign mem_write      = any_gnt & wr_sel;
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = ~reset_n | (req0 & ~gnt0);
    assign m1_waitrequest = ~reset_n | (req1 & ~gnt1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld     <= 1'b0;
            rd_tag     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            rd_vld <= accept_rd;
            if (accept_rd) begin
                rd_tag <= gnt1;
            end
            if (any_gnt) begin
                last_grant <= gnt1;
            end
        end
    end

    assign m0_readdatavalid = rd_vld & ~rd_tag;
    assign m1_readdatavalid = rd_vld &  rd_tag;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Each instance has its own RAM model and a golden memory/arbitration model.
module tb_onchip_mem_arbiter;

    logic clk;
    logic reset_n;

    logic [9:0]  m0_address       [2];
    logic [3:0]  m0_byteenable    [2];
    logic        m0_read          [2];
    logic        m0_write         [2];
    logic [31:0] m0_writedata     [2];
    logic        m0_waitrequest   [2];
    logic [31:0] m0_readdata      [2];
    logic        m0_readdatavalid [2];
    logic [9:0]  m1_address       [2];
    logic [3:0]  m1_byteenable    [2];
    logic        m1_read          [2];
    logic        m1_write         [2];
    logic [31:0] m1_writedata     [2];
    logic        m1_waitrequest   [2];
    logic [31:0] m1_readdata      [2];
    logic        m1_readdatavalid [2];
    logic [9:0]  mem_address      [2];
    logic [3:0]  mem_byteenable   [2];
    logic        mem_chipselect   [2];
    logic        mem_write        [2];
    logic [31:0] mem_writedata    [2];
    logic        mem_clken        [2];
    logic [31:0] mem_readdata     [2];

    logic [31:0] ram  [2][1024];
    logic [31:0] gold [2][1024];
    logic [31:0] rdq  [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .FIXED_PRIO(g)) dut (
            .clk              (clk),
            .reset_n          (reset_n),
            .m0_address       (m0_address[g]),
            .m0_byteenable    (m0_byteenable[g]),
            .m0_read          (m0_read[g]),
            .m0_write         (m0_write[g]),
            .m0_writedata     (m0_writedata[g]),
            .m0_waitrequest   (m0_waitrequest[g]),
            .m0_readdata      (m0_readdata[g]),
            .m0_readdatavalid (m0_readdatavalid[g]),
            .m1_address       (m1_address[g]),
            .m1_byteenable    (m1_byteenable[g]),
            .m1_read          (m1_read[g]),
            .m1_write         (m1_write[g]),
            .m1_writedata     (m1_writedata[g]),
            .m1_waitrequest   (m1_waitrequest[g]),
            .m1_readdata      (m1_readdata[g]),
            .m1_readdatavalid (m1_readdatavalid[g]),
            .mem_address      (mem_address[g]),
            .mem_byteenable   (mem_byteenable[g]),
            .mem_chipselect   (mem_chipselect[g]),
            .mem_write        (mem_write[g]),
            .mem_writedata    (mem_writedata[g]),
            .mem_clken        (mem_clken[g]),
            .mem_readdata     (mem_readdata[g])
        );

        // Single-port RAM with registered read data, byte-lane writes.
        always @(posedge clk) begin
            if (mem_chipselect[g] && mem_clken[g]) begin
                if (mem_write[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_byteenable[g][b])
                            ram[g][mem_address[g]][8*b +: 8] <= mem_writedata[g][8*b +: 8];
                end else begin
                    rdq[g] <= ram[g][mem_address[g]];
                end
            end
        end
        assign mem_readdata[g] = rdq[g];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Golden model state: who won last contention-free/contended grant, and pending read reply.
    int          mdl_last [2];
    bit          mdl_pv   [2];
    int          mdl_pp   [2];
    logic [31:0] mdl_pd   [2];
    bit          cm_r0, cm_r1, cm_w;
    int          cm_win;
    logic [9:0]  cm_a;
    logic [3:0]  cm_be;
    logic [31:0] cm_wd;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!reset_n) begin
                chk($sformatf("rst_wait0[%0d]", g), m0_waitrequest[g], 1);
                chk($sformatf("rst_wait1[%0d]", g), m1_waitrequest[g], 1);
                chk($sformatf("rst_cs[%0d]", g), mem_chipselect[g], 0);
                chk($sformatf("rst_wr[%0d]", g), mem_write[g], 0);
                chk($sformatf("rst_rdv0[%0d]", g), m0_readdatavalid[g], 0);
                chk($sformatf("rst_rdv1[%0d]", g), m1_readdatavalid[g], 0);
                mdl_last[g] = 1;
                mdl_pv[g]   = 0;
            end else begin
                cm_r0 = m0_read[g] | m0_write[g];
                cm_r1 = m1_read[g] | m1_write[g];
                if (cm_r0 && cm_r1)  cm_win = (g == 1) ? 0 : ((mdl_last[g] == 0) ? 1 : 0);
                else if (cm_r0)      cm_win = 0;
                else if (cm_r1)      cm_win = 1;
                else                 cm_win = -1;

                chk($sformatf("wait0[%0d]", g), m0_waitrequest[g], (cm_r0 && cm_win != 0) ? 1 : 0);
                chk($sformatf("wait1[%0d]", g), m1_waitrequest[g], (cm_r1 && cm_win != 1) ? 1 : 0);
                chk($sformatf("cs[%0d]", g), mem_chipselect[g], (cm_win >= 0) ? 1 : 0);
                chk($sformatf("rdv0[%0d]", g), m0_readdatavalid[g], (mdl_pv[g] && mdl_pp[g] == 0) ? 1 : 0);
                chk($sformatf("rdv1[%0d]", g), m1_readdatavalid[g], (mdl_pv[g] && mdl_pp[g] == 1) ? 1 : 0);
                if (mdl_pv[g] && mdl_pp[g] == 0) chk($sformatf("rdata0[%0d]", g), m0_readdata[g], mdl_pd[g]);
                if (mdl_pv[g] && mdl_pp[g] == 1) chk($sformatf("rdata1[%0d]", g), m1_readdata[g], mdl_pd[g]);

                mdl_pv[g] = 0;
                if (cm_win >= 0) begin
                    cm_w  = (cm_win == 0) ? m0_write[g]      : m1_write[g];
                    cm_a  = (cm_win == 0) ? m0_address[g]    : m1_address[g];
                    cm_be = (cm_win == 0) ? m0_byteenable[g] : m1_byteenable[g];
                    cm_wd = (cm_win == 0) ? m0_writedata[g]  : m1_writedata[g];
                    chk($sformatf("mwr[%0d]", g), mem_write[g], cm_w);
                    chk($sformatf("maddr[%0d]", g), mem_address[g], cm_a);
                    chk($sformatf("mbe[%0d]", g), mem_byteenable[g], cm_be);
                    if (cm_w) begin
                        chk($sformatf("mwd[%0d]", g), mem_writedata[g], cm_wd);
                        for (int b = 0; b < 4; b++)
                            if (cm_be[b]) gold[g][cm_a][8*b +: 8] = cm_wd[8*b +: 8];
                    end else begin
                        mdl_pv[g] = 1;
                        mdl_pp[g] = cm_win;
                        mdl_pd[g] = gold[g][cm_a];
                    end
                    mdl_last[g] = cm_win;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input int g, input bit rd, input bit wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m0_read[g] = rd; m0_write[g] = wr; m0_address[g] = a;
        m0_byteenable[g] = be; m0_writedata[g] = d;
    endtask

    task automatic set_m1(input int g, input bit rd, input bit wr, input logic [9:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        m1_read[g] = rd; m1_write[g] = wr; m1_address[g] = a;
        m1_byteenable[g] = be; m1_writedata[g] = d;
    endtask

    task automatic idle_all();
        for (int g = 0; g < 2; g++) begin
            set_m0(g, 0, 0, '0, '0, '0);
            set_m1(g, 0, 0, '0, '0, '0);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 1024; i++) begin
                ram[g][i]  = 32'hC0DE_0000 | i;
                gold[g][i] = 32'hC0DE_0000 | i;
            end
        rdq[0] = '0;
        rdq[1] = '0;
        reset_n = 1'b0;
        idle_all();
        for (int g = 0; g < 2; g++) begin
            set_m0(g, 1, 0, 10'd9, 4'hF, '0);
            set_m1(g, 0, 1, 10'd9, 4'hF, 32'h5555_5555);
        end
        repeat (3) step();

        // Write then read back on port 0 (round-robin instance).
        reset_n = 1'b1;
        idle_all();
        set_m0(0, 0, 1, 10'd5, 4'hF, 32'hDEAD_BEEF);
        @(negedge clk); chk("t1_wr_wait", m0_waitrequest[0], 0);
        step(); set_m0(0, 1, 0, 10'd5, 4'hF, '0);
        @(negedge clk); chk("t1_rd_wait", m0_waitrequest[0], 0);
        step(); idle_all();
        @(negedge clk);
        chk("t1_rdv0", m0_readdatavalid[0], 1);
        chk("t1_rdata0", m0_readdata[0], 32'hDEAD_BEEF);
        chk("t1_rdv1", m1_readdatavalid[0], 0);

        // Round-robin contention straight after reset: grants 0,1,0,1.
        step(); reset_n = 1'b0;
        step(); step(); reset_n = 1'b1;
        set_m0(0, 1, 0, 10'd1, 4'hF, '0);
        set_m1(0, 1, 0, 10'd2, 4'hF, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2_wait0_%0d", k), m0_waitrequest[0], (k % 2 == 1) ? 1 : 0);
            chk($sformatf("t2_wait1_%0d", k), m1_waitrequest[0], (k % 2 == 0) ? 1 : 0);
            if (k > 0) chk($sformatf("t2_rdv0_%0d", k), m0_readdatavalid[0], (k % 2 == 1) ? 1 : 0);
            step();
        end
        idle_all();
        @(negedge clk);
        chk("t2_rdv1_last", m1_readdatavalid[0], 1);
        chk("t2_rdata1_last", m1_readdata[0], 32'hC0DE_0002);

        // Fixed priority: port 1 starves until port 0 drops.
        step();
        set_m0(1, 1, 0, 10'd3, 4'hF, '0);
        set_m1(1, 1, 0, 10'd4, 4'hF, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t3_wait0_%0d", k), m0_waitrequest[1], 0);
            chk($sformatf("t3_wait1_%0d", k), m1_waitrequest[1], 1);
            step();
        end
        set_m0(1, 0, 0, '0, '0, '0);
        @(negedge clk); chk("t3_wait1_free", m1_waitrequest[1], 0);
        step(); idle_all();
        @(negedge clk);
        chk("t3_rdv1", m1_readdatavalid[1], 1);
        chk("t3_rdata1", m1_readdata[1], 32'hC0DE_0004);

        // Byte-lane write at the top address.
        step(); set_m1(0, 0, 1, 10'd1023, 4'hF, 32'hAAAA_AAAA);
        step(); set_m1(0, 0, 1, 10'd1023, 4'h5, 32'h1122_3344);
        step(); set_m1(0, 1, 0, 10'd1023, 4'hF, '0);
        step(); idle_all();
        @(negedge clk);
        chk("t4_rdv1", m1_readdatavalid[0], 1);
        chk("t4_rdata1", m1_readdata[0], 32'hAA22_AA44);

        // Reset while a port-1 read is in flight.
        step(); set_m1(0, 1, 0, 10'd3, 4'hF, '0);
        @(negedge clk); chk("t5_wait1", m1_waitrequest[0], 0);
        step(); idle_all(); reset_n = 1'b0;
        @(negedge clk); chk("t5_rdv1_drop", m1_readdatavalid[0], 0);
        step();
        @(negedge clk); chk("t5_rdv1_drop2", m1_readdatavalid[0], 0);
        step(); reset_n = 1'b1;
        set_m0(0, 1, 0, 10'd4, 4'hF, '0);
        set_m1(0, 1, 0, 10'd6, 4'hF, '0);
        @(negedge clk);
        chk("t5_wait0", m0_waitrequest[0], 0);
        chk("t5_wait1", m1_waitrequest[0], 1);
        step(); set_m0(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("t5_rdv0", m0_readdatavalid[0], 1);
        chk("t5_rdata0", m0_readdata[0], 32'hC0DE_0004);
        chk("t5_wait1_b", m1_waitrequest[0], 0);
        step(); idle_all();
        @(negedge clk); chk("t5_rdv1", m1_readdatavalid[0], 1);

        // Port 0 writes, port 1 reads the same word the next cycle.
        step(); set_m0(0, 0, 1, 10'd7, 4'hF, 32'h1234_5678);
        step(); set_m0(0, 0, 0, '0, '0, '0); set_m1(0, 1, 0, 10'd7, 4'hF, '0);
        step(); idle_all();
        @(negedge clk);
        chk("t6_rdv1", m1_readdatavalid[0], 1);
        chk("t6_rdata1", m1_readdata[0], 32'h1234_5678);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
